// File: rtl/adder_seq_16bit_if.sv
// adder_seq_16bit_if: request/result bundle between the datapath and the 16-bit add sequencer
// Signals:
//   start     request pulse, sampled only when the sequencer is idle
//   op        0 = add, 1 = subtract (subtract only when built with ADDSEQ_SUB_EN)
//   a, b      16-bit operands, latched on an accepted start
//   cin       carry-in for add, latched on an accepted start
//   busy      high from accept until completion
//   done      one-cycle completion pulse
//   result    registered 16-bit result, held until the next completion
//   carry     carry out of bit 15 (add) or no-borrow (subtract)
//   zero      result is all zeros
//   overflow  signed two's-complement overflow
// Modports: master drives requests, slave (the sequencer) drives results.
interface adder_seq_16bit_if;
    logic        start;
    logic        op;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        overflow;
    modport master (
        output start, op, cin, a, b,
        input  busy, done, result, carry, zero, overflow
    );
    modport slave (
        input  start, op, cin, a, b,
        output busy, done, result, carry, zero, overflow
    );
endinterface

// File: rtl/adder_seq_16bit.sv
// adder_seq_16bit: two-cycle 16-bit adder built by time-multiplexing one 8-bit adder
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous active-high reset, priority over start
//   bus   slave side of adder_seq_16bit_if (request, operands, result and flags)
// Build option: define ADDSEQ_SUB_EN to enable op=1 subtract (b inverted, carry-in forced to 1).
// Without it op is ignored and the block always adds with cin.
// Sub-module full_adder_8bit is the shared 8-bit adder slice.
module full_adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'h00, cin_i};
endmodule

module adder_seq_16bit (
    input logic              clk,
    input logic              rst,
    adder_seq_16bit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] b_eff;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic [7:0]  res_lo_q;
    logic [7:0]  fa_a;
    logic [7:0]  fa_b;
    logic [7:0]  fa_sum;
    logic        cin_q;
    logic        cin_eff;
    logic        c_mid_q;
    logic        fa_cin;
    logic        fa_cout;
    logic        busy_q;
    logic        done_q;
    logic        carry_q;
    logic        zero_q;
    logic        ovf_q;
    logic        ovf_d;
`ifdef ADDSEQ_SUB_EN
    logic        op_q;
    // Subtract as a + ~b + 1; the cin port has no effect on a subtract.
    assign b_eff   = op_q ? ~b_q : b_q;
    assign cin_eff = op_q | cin_q;
`else
    logic        unused_op;
    assign unused_op = bus.op;
    assign b_eff     = b_q;
    assign cin_eff   = cin_q;
`endif
    full_adder_8bit u_fa (
        .a_i    (fa_a),
        .b_i    (fa_b),
        .cin_i  (fa_cin),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );
    // Low slice in LO, high slice in HI, zeros otherwise so the adder is quiet when idle.
    always_comb begin
        fa_a     = state_q == LO ? a_q[7:0]   : state_q == HI ? a_q[15:8]   : 8'h00;
        fa_b     = state_q == LO ? b_eff[7:0] : state_q == HI ? b_eff[15:8] : 8'h00;
        fa_cin   = state_q == LO ? cin_eff    : state_q == HI ? c_mid_q     : 1'b0;
        result_d = {fa_sum, res_lo_q};
        ovf_d    = (a_q[15] == b_eff[15]) && (fa_sum[7] != a_q[15]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cin_q    <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            op_q     <= 1'b0;
`endif
            res_lo_q <= 8'h00;
            c_mid_q  <= 1'b0;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        cin_q  <= bus.cin;
`ifdef ADDSEQ_SUB_EN
                        op_q   <= bus.op;
`endif
                        busy_q  <= 1'b1;
                        state_q <= LO;
                    end
                end
                LO: begin
                    // Low byte is staged privately so result never shows a half-updated value.
                    res_lo_q <= fa_sum;
                    c_mid_q  <= fa_cout;
                    state_q  <= HI;
                end
                HI: begin
                    result_q <= result_d;
                    carry_q  <= fa_cout;
                    zero_q   <= result_d == 16'h0000;
                    ovf_q    <= ovf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_adder_seq_16bit.sv
// tb_adder_seq_16bit: self-checking bench for adder_seq_16bit (fixed vectors, corner sequences, random ops)
module tb_adder_seq_16bit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    adder_seq_16bit_if bus ();
    adder_seq_16bit dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] res;
        logic        carry;
        logic        zero;
        logic        ovf;
    } vec_t;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] prev_res = 16'h0000;
    vec_t        tbl[9];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    // Reference: plain unsigned/signed integer arithmetic on the whole 16-bit operands.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
        vec_t v;
        int   s;
        int   u;
        v.a = a; v.b = b; v.cin = cin; v.op = op;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        u = int'(a) + int'(b) + int'(cin);
`ifdef ADDSEQ_SUB_EN
        if (op) begin
            s = int'($signed(a)) - int'($signed(b));
            u = int'(a) - int'(b);
        end
        v.carry = op ? (a >= b) : (u > 65535);
`else
        v.carry = u > 65535;
`endif
        v.res  = u[15:0];
        v.zero = v.res == 16'h0000;
        v.ovf  = (s > 32767) || (s < -32768);
        return v;
    endfunction
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.op = op;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    // Accept, check two-edge latency and held result, then compare result and flags in the done cycle.
    task automatic run_op(input vec_t v, input string name);
        issue(v.a, v.b, v.cin, v.op);
        check({name, " busy_after_accept"}, 32'(bus.busy), 1);
        check({name, " done_early"}, 32'(bus.done), 0);
        @(posedge clk); #1;
        check({name, " done_mid"}, 32'(bus.done), 0);
        check({name, " result_held"}, 32'(bus.result), 32'(prev_res));
        @(posedge clk); #1;
        check({name, " done"}, 32'(bus.done), 1);
        check({name, " busy_end"}, 32'(bus.busy), 0);
        check({name, " result"}, 32'(bus.result), 32'(v.res));
        check({name, " flags"}, {29'h0, bus.carry, bus.zero, bus.overflow}, {29'h0, v.carry, v.zero, v.ovf});
        prev_res = v.res;
    endtask
    task automatic check_zeroed(input string name);
        check({name, " done"}, 32'(bus.done), 0);
        check({name, " busy"}, 32'(bus.busy), 0);
        check({name, " result"}, 32'(bus.result), 0);
        check({name, " flags"}, {29'h0, bus.carry, bus.zero, bus.overflow}, 0);
    endtask
    initial begin
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
`ifdef ADDSEQ_SUB_EN
        tbl[5] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
`else
        tbl[5] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0};
`endif
        rst = 1'b1;
        bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1; bus.op = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check_zeroed("reset_with_start");
        end
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) run_op(tbl[i], $sformatf("vec%0d", i));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 0);
        check("idle_not_busy", 32'(bus.busy), 0);
        // start pulsed during LO with other operands must be ignored.
        issue(16'h0102, 16'h0304, 1'b0, 1'b0);
        bus.start = 1'b1; bus.a = 16'hF00D; bus.b = 16'h1111; bus.cin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("busy_ignore done", 32'(bus.done), 1);
        check("busy_ignore result", 32'(bus.result), 32'h0406);
        @(posedge clk); #1;
        check("busy_ignore not_reaccepted", 32'(bus.busy), 0);
        prev_res = 16'h0406;
        // reset while in HI aborts with no done pulse.
        issue(16'h2222, 16'h3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zeroed("abort_hi");
        @(posedge clk); #1;
        check("abort_no_late_done", 32'(bus.done), 0);
        prev_res = 16'h0000;
        run_op(model(16'h4321, 16'h1234, 1'b0, 1'b0), "after_abort");
        for (int i = 0; i < 40; i++) begin
            run_op(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), $sformatf("rand%0d", i));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
